// File: rtl/ysyx_22050243_wb_arb_if.sv
// Writeback request bundle shared by the EX (A) and LSU load-return (B) sources.
// The master side is the pair of requesters; the slave side is the arbiter.
interface ysyx_22050243_wb_arb_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [63:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [63:0] b_data;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/ysyx_22050243_wb_arb.sv
// GPR write-port arbiter between EX results and LSU load returns.
// It also tracks a per-register bitmap of outstanding loads for ID.
module ysyx_22050243_wb_arb (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_22050243_wb_arb_if.slave        bus,
    input  logic                         ld_issue,
    input  logic [4:0]                   ld_rd,
    output logic                         w_e,
    output logic [4:0]                   waddr,
    output logic [63:0]                  wdata,
    output logic [31:0]                  pend,
    output logic                         last_grant
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t       prio;
    prio_t       prio_next;
    logic        a_grant;
    logic        b_grant;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio <= PRIO_A;
        end else begin
            prio <= prio_next;
        end
    end

    // Readies are held low while reset is asserted, even with valid requests.
    always_comb begin
        a_grant   = 1'b0;
        b_grant   = 1'b0;
        prio_next = prio;
        if (rst) begin
            a_grant = bus.a_valid & (~bus.b_valid | (prio == PRIO_A));
            b_grant = bus.b_valid & (~bus.a_valid | (prio == PRIO_B));
        end
        if (a_grant) begin
            prio_next = PRIO_B;
        end else if (b_grant) begin
            prio_next = PRIO_A;
        end
    end

    assign bus.a_ready = a_grant;
    assign bus.b_ready = b_grant;
    assign last_grant  = (prio == PRIO_B);

    // x0 writes still occupy the slot but never raise the write enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_e   <= 1'b0;
            waddr <= 5'd0;
            wdata <= 64'd0;
        end else if (a_grant) begin
            w_e   <= (bus.a_addr != 5'd0);
            waddr <= bus.a_addr;
            wdata <= bus.a_data;
        end else if (b_grant) begin
            w_e   <= (bus.b_addr != 5'd0);
            waddr <= bus.b_addr;
            wdata <= bus.b_data;
        end else begin
            w_e   <= 1'b0;
        end
    end

    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (ld_issue && (ld_rd != 5'd0)) begin
            set_mask = 32'd1 << ld_rd;
        end
        if (b_grant) begin
            clr_mask = 32'd1 << bus.b_addr;
        end
    end

    // A load issued in the same cycle its register returns keeps the bit set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= 32'd0;
        end else begin
            pend <= ((pend & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
        end
    end

endmodule

// File: doc/ysyx_22050243_wb_arb.md
# ysyx_22050243_wb_arb

GPR write-port arbiter and load scoreboard for the ysyx_22050243 core. Two writeback sources share the GPR file's single write port through valid/ready handshakes:
- A: the EX/ALU pipeline.
- B: the variable-latency LSU load return.

The block drives the GPR write port from a registered stage. It also keeps a per-register pending bitmap of outstanding loads for the hazard/stall logic in ID.

## Interface
Parameters: none (widths fixed: 32 registers, 5-bit address, 64-bit data).

- clk  in  1  core clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- a_valid  in  1  EX writeback request
- a_ready  out  1  EX request accepted this cycle
- a_addr  in  5  EX destination register
- a_data  in  64  EX result
- b_valid  in  1  LSU load-return request
- b_ready  out  1  LSU request accepted this cycle
- b_addr  in  5  load destination register
- b_data  in  64  load data
- ld_issue  in  1  LSU issued a load this cycle
- ld_rd  in  5  destination register of the issued load
- w_e  out  1  GPR write enable (registered)
- waddr  out  5  GPR write address (registered)
- wdata  out  64  GPR write data (registered)
- pend  out  32  bit i = 1 while a load to xi is outstanding; bit 0 always 0
- last_grant  out  1  0 = A holds priority next, 1 = B holds priority next (registered)

## Operation
- Handshake: a transfer happens when valid & ready are both high in the same cycle. A requester keeps valid, addr and data stable until it sees ready. Valid is never withdrawn before acceptance.
- Grant (combinational, single cycle):
  - a_ready = a_valid & (~b_valid | prio==A)
  - b_ready = b_valid & (~a_valid | prio==B)
  - a_ready and b_ready are never high together.
- Priority update: after any grant to A, prio becomes B. After any grant to B, prio becomes A. With no grant, prio is unchanged. last_grant mirrors prio. Reset: prio = A.
- Output stage, on each posedge:
  - If a grant occurred: w_e <= (granted addr != 0), waddr <= granted addr, wdata <= granted data.
  - Otherwise: w_e <= 0; waddr and wdata hold their values.
- x0: a write to x0 is accepted, consumes the grant and flips priority, but produces w_e = 0.
- Scoreboard, evaluated at the posedge:
  - set mask = ld_issue & ld_rd != 0 → bit ld_rd
  - clear mask = b_valid & b_ready → bit b_addr
  - pend <= (pend & ~clear) | set, so set wins when both hit the same register.
- An A write to a register whose pend bit is set is granted normally and does not change pend. Preventing this WAW case is the hazard unit's job.
- A B return to a register whose pend bit is clear is written normally. The clear is a no-op.

## Timing
- Reset (rst low, asynchronous): w_e=0, waddr=0, wdata=0, pend=0, prio=A, last_grant=0. a_ready and b_ready stay low while rst is low.
- Mid-operation reset drops any granted-but-unwritten result and clears all pending bits.
- Latency: a request accepted in cycle N appears on w_e/waddr/wdata in cycle N+1, and the GPR commits at the end of N+1. The GPR's internal bypass covers same-cycle reads.
- Throughput: one write per cycle. Under continuous contention, A and B alternate.
- Starvation bound: a waiting requester is granted within 2 cycles.
- A pend bit set by ld_issue in cycle N is visible in cycle N+1. A bit cleared by a B accept in cycle N reads 0 from N+1, the same cycle the data is on the write port.

## Test plan
- Reset: hold rst low for 3 cycles with a_valid=b_valid=1 → a_ready=b_ready=0. After release, all outputs are 0 and the first contended grant goes to A.
- Single A: a_valid=1, a_addr=5, a_data=0x1234 in cycle N → a_ready=1 in N. In N+1, w_e=1, waddr=5, wdata=0x1234, last_grant=1. In N+2, w_e=0.
- Contention: both valid for 4 cycles (A to x3 = 0xA, B to x4 = 0xB, next beats new data) → grants alternate A,B,A,B. The write port shows x3, x4, x3, x4 in cycles N+1..N+4, and no cycle has both readies high.
- Scoreboard:
  - ld_issue=1, ld_rd=7 at N → pend[7]=1 at N+1.
  - B returns x7 = 0xDEAD at M → pend[7]=0 and w_e=1, waddr=7, wdata=0xDEAD at M+1.
  - Same-cycle B clear and ld_issue for x7 → pend[7] stays 1.
- x0: A write to x0 with data 0xFFFF → a_ready=1, w_e=0 next cycle, priority flips. ld_issue with ld_rd=0 → pend stays 0.
- Async reset mid-stream: assert rst between clock edges while a grant is in flight and pend=0x0000_0080 → outputs go to 0 immediately, and no write occurs after release.
